deck_shuffler: RTL
==================

# deck_shuffler

Memory-port initiator that builds a 52-card deck in the shared dual-port card RAM and shuffles it in place with a Fisher-Yates pass. It drives the RAM's primary write/read port (write enable, address, write data) and consumes that port's registered read data. The game controller reads the finished deck through the RAM's second read port. Randomness comes from an internal seedable 32-bit Galois LFSR.

## Interface
- DATA_WIDTH, 32, RAM word width; card index is zero-extended into it
- ADDRESS_WIDTH, 12, RAM address width
- BASE_ADDR, 0, address of deck slot 0; slots occupy BASE_ADDR..BASE_ADDR+51
- LFSR_SEED, 32'hACE12B7F, LFSR reset value and replacement for a zero seed
- clk  input  1  single clock, all state on rising edge
- reset_n  input  1  asynchronous, active-low reset
- start  input  1  begin fill+shuffle; sampled only in IDLE
- seed_load  input  1  load `seed` into LFSR; sampled only in IDLE
- seed  input  32  new LFSR value; zero maps to LFSR_SEED
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse when the shuffle completes
- mem_wEn  output  1  RAM primary-port write enable
- mem_addr  output  ADDRESS_WIDTH  RAM primary-port address
- mem_dataIn  output  DATA_WIDTH  RAM write data
- mem_dataOut  input  DATA_WIDTH  RAM primary-port read data; valid one cycle after a read address (wEn=0) is presented; holds its value while wEn=1

## Operation
- Clock and reset: one clock (clk); reset_n is asynchronous, active-low.
- States: IDLE, FILL, PICK, RD_I, RD_J, WR_I, WR_J, DONE.
- IDLE:
  - seed_load=1 loads the LFSR (seed, or LFSR_SEED if seed==0).
  - start=1 goes to FILL with k=0.
  - If both are high, the seed loads first and start proceeds the same cycle.
- FILL: writes addr BASE_ADDR+k, data k, for k=0..51. After k=51, set i=51 and go to PICK.
- PICK, each cycle:
  - r = lfsr[5:0] & mask(i).
  - mask is the smallest 2^n-1 >= i: 1 for i=1; 3 for 2-3; 7 for 4-7; 15 for 8-15; 31 for 16-31; 63 for 32-51.
  - If r <= i: j=r, go to RD_I.
  - Otherwise stay in PICK.
  - The LFSR advances every PICK cycle, accept or reject.
- LFSR step: b=l[0]; l=l>>1; if b, l ^= 32'h80200003. It advances only in PICK.
- RD_I: read addr BASE_ADDR+i.
- RD_J: read addr BASE_ADDR+j. mem_dataOut = old card at i; register it as card_i.
- WR_I: write addr BASE_ADDR+i, mem_dataIn = mem_dataOut (old card at j, passed through combinationally).
- WR_J: write addr BASE_ADDR+j, mem_dataIn = card_i. Then:
  - if i==1 go to DONE;
  - else i=i-1 and go to PICK.
- j==i: the swap still runs all four cycles and rewrites the same value. This is legal.
- DONE: pulse done for one cycle, then go to IDLE.
- start and seed_load are ignored while busy. No abort input.
- mem_* are decoded from registered state and counters. In IDLE, PICK and DONE: mem_wEn=0, mem_addr=0, mem_dataIn=0.

## Timing
- Reset values: busy=0, done=0, mem_wEn=0, mem_addr=0, mem_dataIn=0, state=IDLE, lfsr=LFSR_SEED, i=k=j=0, card_i=0.
- start seen at edge t: busy=1 and the first FILL write are visible in cycle t+1.
- FILL takes exactly 52 cycles.
- Each of the 51 swaps takes (PICK cycles, >=1) + 4 cycles.
- Total from start to done = 52 + 51*4 + total PICK cycles + 1. The minimum is 308 cycles.
- done is high for exactly one cycle. busy falls in the cycle after done, with IDLE entered.
- Reset mid-operation:
  - immediate return to reset values, including the LFSR;
  - RAM contents are left partially filled or shuffled and are not restored;
  - the next start refills from scratch.
- No read-after-write hazard: the block never reads a slot in the cycle after writing it without an intervening read address.

## Test plan
- Fill trace: reset, seed_load with seed=32'h1, then start. The first 52 cycles show mem_wEn=1, addr BASE_ADDR+k, data k for k=0..51.
- Permutation: run to done with seed 32'h1. The RAM model holds each value 0..51 exactly once at BASE_ADDR..+51, and done pulses for exactly one cycle.
- Determinism and zero seed: seeds 32'h0 and 32'hACE12B7F produce identical write traces. Seed 32'h1 produces a trace matching the reference LFSR/rejection model swap-for-swap.
- Swap data path: each WR_I writes the value the model held at j, and the following WR_J writes the value held at i. A preloaded RAM pattern confirms the 1-cycle read latency alignment.
- Ignored inputs: pulse start and seed_load mid-shuffle. The trace and final deck are unchanged versus the unperturbed run.
- Reset mid-shuffle: assert reset_n=0 at cycle 150. All outputs go 0 immediately. A restart with the same seed reproduces the full deck from a clean fill.

Source files
------------

// File: rtl/deck_shuffler.sv
// Builds a 52-card deck in the card RAM through its primary port, then shuffles it
// in place with a Fisher-Yates pass driven by a seedable 32-bit Galois LFSR.
module deck_shuffler #(
  parameter int          DATA_WIDTH    = 32,
  parameter int          ADDRESS_WIDTH = 12,
  parameter int          BASE_ADDR     = 0,
  parameter logic [31:0] LFSR_SEED     = 32'hACE12B7F
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic                     seed_load,
  input  logic [31:0]              seed,
  output logic                     busy,
  output logic                     done,
  output logic                     mem_wEn,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_dataIn,
  input  logic [DATA_WIDTH-1:0]    mem_dataOut
);

  localparam logic [5:0]               LAST_CARD = 6'd51;
  localparam logic [31:0]              LFSR_TAPS = 32'h80200003;
  localparam logic [ADDRESS_WIDTH-1:0] BASE      = ADDRESS_WIDTH'(BASE_ADDR);

  typedef enum logic [2:0] {
    S_IDLE, S_FILL, S_PICK, S_RD_I, S_RD_J, S_WR_I, S_WR_J, S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [31:0]           lfsr_q, lfsr_d;
  logic [5:0]            k_q, k_d;
  logic [5:0]            i_q, i_d;
  logic [5:0]            j_q, j_d;
  logic [DATA_WIDTH-1:0] card_i_q, card_i_d;

  logic [31:0] lfsr_next;
  logic [5:0]  pick_r;

  // Smallest all-ones mask covering n; candidates above n are rejected, keeping j uniform.
  function automatic logic [5:0] mask_for(input logic [5:0] n);
    logic [5:0] m;
    if (n >= 6'd32)      m = 6'd63;
    else if (n >= 6'd16) m = 6'd31;
    else if (n >= 6'd8)  m = 6'd15;
    else if (n >= 6'd4)  m = 6'd7;
    else if (n >= 6'd2)  m = 6'd3;
    else                 m = 6'd1;
    return m;
  endfunction

  assign lfsr_next = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 32'h0);
  assign pick_r    = lfsr_q[5:0] & mask_for(i_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      lfsr_q   <= LFSR_SEED;
      k_q      <= '0;
      i_q      <= '0;
      j_q      <= '0;
      card_i_q <= '0;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      k_q      <= k_d;
      i_q      <= i_d;
      j_q      <= j_d;
      card_i_q <= card_i_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    lfsr_d   = lfsr_q;
    k_d      = k_q;
    i_d      = i_q;
    j_d      = j_q;
    card_i_d = card_i_q;
    case (state_q)
      S_IDLE: begin
        if (seed_load) lfsr_d = (seed == 32'h0) ? LFSR_SEED : seed;
        if (start) begin
          k_d     = '0;
          state_d = S_FILL;
        end
      end
      S_FILL: begin
        if (k_q == LAST_CARD) begin
          i_d     = LAST_CARD;
          state_d = S_PICK;
        end else begin
          k_d = k_q + 6'd1;
        end
      end
      S_PICK: begin
        lfsr_d = lfsr_next;
        if (pick_r <= i_q) begin
          j_d     = pick_r;
          state_d = S_RD_I;
        end
      end
      S_RD_I: state_d = S_RD_J;
      S_RD_J: begin
        // Read data for the RD_I address arrives now.
        card_i_d = mem_dataOut;
        state_d  = S_WR_I;
      end
      S_WR_I: state_d = S_WR_J;
      S_WR_J: begin
        if (i_q == 6'd1) begin
          state_d = S_DONE;
        end else begin
          i_d     = i_q - 6'd1;
          state_d = S_PICK;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy       = (state_q != S_IDLE);
    done       = (state_q == S_DONE);
    mem_wEn    = 1'b0;
    mem_addr   = '0;
    mem_dataIn = '0;
    case (state_q)
      S_FILL: begin
        mem_wEn    = 1'b1;
        mem_addr   = BASE + ADDRESS_WIDTH'(k_q);
        mem_dataIn = DATA_WIDTH'(k_q);
      end
      S_RD_I: mem_addr = BASE + ADDRESS_WIDTH'(i_q);
      S_RD_J: mem_addr = BASE + ADDRESS_WIDTH'(j_q);
      S_WR_I: begin
        // RAM holds the card read from j while wEn is high, so it passes straight through.
        mem_wEn    = 1'b1;
        mem_addr   = BASE + ADDRESS_WIDTH'(i_q);
        mem_dataIn = mem_dataOut;
      end
      S_WR_J: begin
        mem_wEn    = 1'b1;
        mem_addr   = BASE + ADDRESS_WIDTH'(j_q);
        mem_dataIn = card_i_q;
      end
      default: ;
    endcase
  end

endmodule
